// File: rtl/riscv_mmio_pkg.sv
// Shared definitions for the memory-mapped peripherals on the data store path.
//   UART_*_OFS : register offsets from a peripheral's base address
//   ST_*       : bit positions inside the UART STATUS register
//   uart_tx_state_t : transmitter frame state
package riscv_mmio_pkg;

  localparam logic [31:0] UART_TXDATA_OFS = 32'd0;
  localparam logic [31:0] UART_STATUS_OFS = 32'd4;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count.
//   clk, reset      : clock (rising edge), asynchronous active-low reset
//   push / din      : write strobe and data; ignored while full, even if a pop
//                     happens in the same cycle
//   pop / dout      : read strobe; dout always shows the head entry
//   full, empty     : occupancy flags
//   count           : entries held, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_push_ok = push & ~full;
  assign w_pop_ok  = pop & ~empty;

  // Head is read without a register so a consumer can load it in the same
  // cycle it decides to pop.
  assign dout = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= din;
  end

  // Power-of-two depth: pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the processor store path.
//   clk, reset : clock (rising edge), asynchronous active-low reset
//   wr_en      : store strobe
//   addr       : byte address; TXDATA at BASE_ADDR, STATUS at BASE_ADDR+4
//   wdata      : store data; TXDATA uses [7:0], STATUS write bit3=1 clears overflow
//   rd_data    : STATUS value when addr hits STATUS, else 0 (combinational)
//   sel        : addr hits either register (combinational)
//   tx         : serial line, idle high
//   irq        : high while FIFO empty and transmitter idle
module mmio_uart_tx
  import riscv_mmio_pkg::*;
#(
  parameter int          CLK_FREQ   = 50_000_000,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rd_data,
  output logic        sel,
  output logic        tx,
  output logic        irq
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_t   r_state;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             r_irq;
  logic             r_ovf;

  logic             w_txdata_hit;
  logic             w_status_hit;
  logic             w_push;
  logic             w_push_ok;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [7:0]       w_fifo_dout;
  logic             w_bit_end;
  logic             w_idle_next;
  logic             w_empty_next;
  logic             w_ovf_clr;
  logic [31:0]      w_status;
  logic             w_unused;

  assign w_txdata_hit = (addr == BASE_ADDR + UART_TXDATA_OFS);
  assign w_status_hit = (addr == BASE_ADDR + UART_STATUS_OFS);
  assign sel          = w_txdata_hit | w_status_hit;
  assign w_push       = wr_en & w_txdata_hit;
  assign w_push_ok    = w_push & ~w_full;
  assign w_pop        = (r_state == IDLE) & ~w_empty;
  assign w_ovf_clr    = wr_en & w_status_hit & wdata[ST_OVF];
  assign w_unused     = ^wdata[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (wdata[7:0]),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_comb begin
    w_status                      = '0;
    w_status[ST_BUSY]             = (r_state != IDLE);
    w_status[ST_FULL]             = w_full;
    w_status[ST_EMPTY]            = w_empty;
    w_status[ST_OVF]              = r_ovf;
    w_status[ST_CNT_LSB +: 8]     = 8'(w_count);
  end

  assign rd_data = w_status_hit ? w_status : '0;

  // Overflow is sticky; set and clear target different addresses so they
  // can never coincide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 r_ovf <= 1'b0;
    else if (w_push & w_full)   r_ovf <= 1'b1;
    else if (w_ovf_clr)         r_ovf <= 1'b0;
  end

  assign w_bit_end = (r_baud_cnt == CNT_W'(DIV - 1));

  // irq is registered from the post-edge state so it exactly tracks
  // "FIFO empty and transmitter idle".
  assign w_idle_next  = ((r_state == IDLE) & w_empty) |
                        ((r_state == STOP) & w_bit_end);
  assign w_empty_next = w_pop ? ((w_count == CW'(1)) & ~w_push_ok)
                              : (w_empty & ~w_push_ok);

  // r_tx is loaded with the level of the state being entered, so the line
  // changes on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_irq      <= 1'b1;
    end else begin
      r_irq <= w_idle_next & w_empty_next;
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (!w_empty) begin
            r_shift    <= w_fifo_dout;
            r_state    <= START;
            r_baud_cnt <= '0;
            r_tx       <= 1'b0;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_state    <= DATA;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_tx       <= r_shift[0];
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx  = r_tx;
  assign irq = r_irq;

endmodule
